umi_reg_host: RTL and testbench
===============================

Name: umi_reg_host

Overview:
- Register-side initiator that turns single-beat register read/write requests into UMI request transactions and returns the matching UMI response as a register-style completion.
- Mirror of umi_regif: umi_regif terminates UMI requests into a register port; umi_reg_host originates them.
- Used by test and control logic to reach any UMI device, including a umi_regif-fronted register file.
- One transaction outstanding at a time; responses are tagged so that stale ones are never accepted.

Parameters:
- CW, 32, UMI command width.
- AW, 64, UMI address width.
- DW, 256, UMI data width.
- RW, 32, register data width; must be a power of two with 8 <= RW <= DW.
- SRCADDR, 64'h0, return address placed in uhost_req_srcaddr; responses must carry this value in dstaddr.
- TIMEOUT, 1024, cycles to wait for a response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reg_req_valid  in  1  register request valid
- reg_req_ready  out  1  register request ready
- reg_req_write  in  1  1 = write, 0 = read
- reg_req_addr  in  AW  target address
- reg_req_wrdata  in  RW  write data
- reg_resp_valid  out  1  completion valid
- reg_resp_ready  in  1  completion ready
- reg_resp_rddata  out  RW  read data (0 for writes and errors)
- reg_resp_err  out  2  UMI error code; 2'b11 = timeout
- uhost_req_valid  out  1  UMI request valid
- uhost_req_ready  in  1  UMI request ready
- uhost_req_cmd  out  CW  UMI request command
- uhost_req_dstaddr  out  AW  UMI request destination address
- uhost_req_srcaddr  out  AW  UMI request source address
- uhost_req_data  out  DW  UMI request data
- uhost_resp_valid  in  1  UMI response valid
- uhost_resp_ready  out  1  UMI response ready
- uhost_resp_cmd  in  CW  UMI response command
- uhost_resp_dstaddr  in  AW  UMI response destination address
- uhost_resp_srcaddr  in  AW  UMI response source address (unused)
- uhost_resp_data  in  DW  UMI response data

Behaviour:
- Reset: state=IDLE, tag=0, timeout counter=0. Outputs: reg_req_ready=0, reg_resp_valid=0, reg_resp_rddata=0, reg_resp_err=0, uhost_req_valid=0, all uhost_req_* buses=0, uhost_resp_ready=0. All outputs are registered.
- Reset asserted mid-transaction aborts it silently; no completion is issued.
- FSM states IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE: reg_req_ready=1 (from the first clk after reset release). On the cycle N handshake, capture the request and go to REQ; uhost_req_valid=1 from cycle N+1; reg_req_ready=0 in every state other than IDLE.
- uhost_req_cmd fields:
  - [4:0] opcode: 5'h03 REQ_WRITE or 5'h01 REQ_READ.
  - [7:5] size = log2(RW/8).
  - [15:8] len = 0.
  - [22] eom = 1; [23] eof = 1.
  - [31:27] hostid = tag.
  - All other bits 0.
- uhost_req_dstaddr=reg_req_addr; uhost_req_srcaddr=SRCADDR.
- uhost_req_data: writes = zero-extended wrdata; reads = 0.
- REQ: hold all uhost_req_* stable until uhost_req_ready. On the handshake: drop valid next cycle, tag <= tag+1 (wraps 31->0), clear the counter, go to WAIT.
- uhost_resp_ready=1 in all states once out of reset. Responses accepted outside WAIT are discarded.
- A response matches only when all of the following hold:
  - opcode is 5'h04 RESP_WRITE for a write, or 5'h02 RESP_READ for a read;
  - dstaddr == SRCADDR;
  - cmd[31:27] == tag used by the request.
- In WAIT, non-matching responses are discarded and the FSM stays in WAIT.
- Matching response: next cycle reg_resp_valid=1, reg_resp_err=cmd[26:25], reg_resp_rddata=data[RW-1:0] for reads and 0 for writes; go to RESP.
- Timeout (TIMEOUT>0): the counter increments every WAIT cycle. When it reaches TIMEOUT with no match, go to RESP with err=2'b11 and rddata=0.
- A match on the same cycle as expiry wins over the timeout.
- A late response arriving after a timeout is dropped (tag mismatch or wrong state).
- RESP: hold completion data until reg_resp_ready; on the handshake clear reg_resp_valid and return to IDLE. reg_req_ready=1 on the following cycle.
- Minimum latency, register accept to completion valid, with ready always high and a zero-latency device: 3 cycles plus device latency.

Test Plan:
- Write 0xDEADBEEF to addr 0x40, device acks with RESP_WRITE, hostid 0, err 0 -> UMI req opcode 03, size 2, data 0xDEADBEEF; completion err=0, rddata=0; next request carries hostid 1.
- Read addr 0x40 from a umi_regif+la_spram model -> UMI opcode 01; completion rddata=0xDEADBEEF, err=0.
- uhost_req_ready held low 5 cycles -> request fields stable, reg_req_ready=0 throughout, no completion issued early.
- With TIMEOUT=8 and no response -> completion err=2'b11 after 8 WAIT cycles; a response with the old hostid arriving later is dropped; the next read completes normally.
- Inject a response with hostid+1 or wrong dstaddr during WAIT, then the correct one -> only the correct response completes the transaction.
- Assert reset while in WAIT -> all outputs 0 immediately; reg_req_ready=1 on the first clk after release; tag=0.

Source files
------------

// File: rtl/umi_reg_host.sv
// Register-side UMI initiator: one register read/write becomes one UMI request, and the matching response becomes a completion.
// Latency: 3 cycles from register accept to completion valid, plus device latency. Only one transaction is outstanding.
// Backpressure: reg_req_ready is high only in IDLE. The UMI request holds until uhost_req_ready. The completion holds until reg_resp_ready.
module umi_reg_host #(
    parameter int          CW      = 32,
    parameter int          AW      = 64,
    parameter int          DW      = 256,
    parameter int          RW      = 32,
    parameter logic [AW-1:0] SRCADDR = 64'h0,
    parameter int          TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_req_valid,
    output logic          reg_req_ready,
    input  logic          reg_req_write,
    input  logic [AW-1:0] reg_req_addr,
    input  logic [RW-1:0] reg_req_wrdata,
    output logic          reg_resp_valid,
    input  logic          reg_resp_ready,
    output logic [RW-1:0] reg_resp_rddata,
    output logic [1:0]    reg_resp_err,
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    localparam logic [2:0] SIZE      = 3'($clog2(RW / 8));
    localparam logic [4:0] REQ_READ  = 5'h01;
    localparam logic [4:0] REQ_WRITE = 5'h03;
    localparam logic [4:0] RESP_READ = 5'h02;
    localparam logic [4:0] RESP_WR   = 5'h04;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [4:0]    tag, tag_nxt;
    logic [31:0]   cnt, cnt_nxt;
    logic          is_write, is_write_nxt;
    logic          reg_req_ready_nxt;
    logic          reg_resp_valid_nxt;
    logic [RW-1:0] reg_resp_rddata_nxt;
    logic [1:0]    reg_resp_err_nxt;
    logic          uhost_req_valid_nxt;
    logic [CW-1:0] uhost_req_cmd_nxt;
    logic [AW-1:0] uhost_req_dstaddr_nxt;
    logic [AW-1:0] uhost_req_srcaddr_nxt;
    logic [DW-1:0] uhost_req_data_nxt;
    logic [CW-1:0] req_cmd;
    logic          opc_ok;
    logic          resp_match;
    logic          expired;

    // The source address and the unused response bits are intentionally ignored.
    logic unused_resp;
    assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd, uhost_resp_data};

    // Build the request command: one beat of RW bits, single-message (eom/eof), hostid = current tag.
    always_comb begin
        req_cmd        = '0;
        req_cmd[4:0]   = reg_req_write ? REQ_WRITE : REQ_READ;
        req_cmd[7:5]   = SIZE;
        req_cmd[22]    = 1'b1;
        req_cmd[23]    = 1'b1;
        req_cmd[31:27] = tag;
    end

    // The held request cmd still carries the tag that was issued, so compare against it.
    always_comb begin
        opc_ok     = is_write ? (uhost_resp_cmd[4:0] == RESP_WR)
                              : (uhost_resp_cmd[4:0] == RESP_READ);
        resp_match = uhost_resp_valid && uhost_resp_ready && opc_ok &&
                     (uhost_resp_dstaddr == SRCADDR) &&
                     (uhost_resp_cmd[31:27] == uhost_req_cmd[31:27]);
        expired    = (TIMEOUT > 0) && (cnt == 32'(TIMEOUT - 1));
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt             = state;
        tag_nxt               = tag;
        cnt_nxt               = cnt;
        is_write_nxt          = is_write;
        reg_req_ready_nxt     = 1'b0;
        reg_resp_valid_nxt    = reg_resp_valid;
        reg_resp_rddata_nxt   = reg_resp_rddata;
        reg_resp_err_nxt      = reg_resp_err;
        uhost_req_valid_nxt   = uhost_req_valid;
        uhost_req_cmd_nxt     = uhost_req_cmd;
        uhost_req_dstaddr_nxt = uhost_req_dstaddr;
        uhost_req_srcaddr_nxt = uhost_req_srcaddr;
        uhost_req_data_nxt    = uhost_req_data;
        case (state)
            IDLE: begin
                reg_req_ready_nxt = 1'b1;
                if (reg_req_valid && reg_req_ready) begin
                    state_nxt             = REQ;
                    reg_req_ready_nxt     = 1'b0;
                    is_write_nxt          = reg_req_write;
                    uhost_req_valid_nxt   = 1'b1;
                    uhost_req_cmd_nxt     = req_cmd;
                    uhost_req_dstaddr_nxt = reg_req_addr;
                    uhost_req_srcaddr_nxt = SRCADDR;
                    uhost_req_data_nxt    = reg_req_write ? DW'(reg_req_wrdata) : '0;
                end
            end
            REQ: begin
                if (uhost_req_ready) begin
                    state_nxt           = WAIT;
                    uhost_req_valid_nxt = 1'b0;
                    tag_nxt             = tag + 5'd1;
                    cnt_nxt             = '0;
                end
            end
            WAIT: begin
                if (resp_match) begin
                    state_nxt           = RESP;
                    reg_resp_valid_nxt  = 1'b1;
                    reg_resp_err_nxt    = uhost_resp_cmd[26:25];
                    reg_resp_rddata_nxt = is_write ? '0 : uhost_resp_data[RW-1:0];
                end else if (expired) begin
                    state_nxt           = RESP;
                    reg_resp_valid_nxt  = 1'b1;
                    reg_resp_err_nxt    = 2'b11;
                    reg_resp_rddata_nxt = '0;
                end else if (TIMEOUT > 0) begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            RESP: begin
                if (reg_resp_ready) begin
                    state_nxt           = IDLE;
                    reg_resp_valid_nxt  = 1'b0;
                    reg_resp_err_nxt    = 2'b00;
                    reg_resp_rddata_nxt = '0;
                    reg_req_ready_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and all outputs are registered. Reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            tag               <= '0;
            cnt               <= '0;
            is_write          <= 1'b0;
            reg_req_ready     <= 1'b0;
            reg_resp_valid    <= 1'b0;
            reg_resp_rddata   <= '0;
            reg_resp_err      <= '0;
            uhost_req_valid   <= 1'b0;
            uhost_req_cmd     <= '0;
            uhost_req_dstaddr <= '0;
            uhost_req_srcaddr <= '0;
            uhost_req_data    <= '0;
            uhost_resp_ready  <= 1'b0;
        end else begin
            state             <= state_nxt;
            tag               <= tag_nxt;
            cnt               <= cnt_nxt;
            is_write          <= is_write_nxt;
            reg_req_ready     <= reg_req_ready_nxt;
            reg_resp_valid    <= reg_resp_valid_nxt;
            reg_resp_rddata   <= reg_resp_rddata_nxt;
            reg_resp_err      <= reg_resp_err_nxt;
            uhost_req_valid   <= uhost_req_valid_nxt;
            uhost_req_cmd     <= uhost_req_cmd_nxt;
            uhost_req_dstaddr <= uhost_req_dstaddr_nxt;
            uhost_req_srcaddr <= uhost_req_srcaddr_nxt;
            uhost_req_data    <= uhost_req_data_nxt;
            uhost_resp_ready  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_umi_reg_host.sv
// Bench for umi_reg_host: directed scenarios followed by random transactions against a register-file device model.
// Latency: the completion is expected on the exact cycle the reference timing gives.
// Backpressure: request and completion stalls are both exercised.
module tb_umi_reg_host;
    localparam int          CW  = 32;
    localparam int          AW  = 64;
    localparam int          DW  = 256;
    localparam int          RW  = 32;
    localparam int          TO  = 8;
    localparam logic [63:0] SRC = 64'h0000_0000_CAFE_0000;

    logic          clk;
    logic          reset;
    logic          reg_req_valid, reg_req_ready, reg_req_write;
    logic [AW-1:0] reg_req_addr;
    logic [RW-1:0] reg_req_wrdata;
    logic          reg_resp_valid, reg_resp_ready;
    logic [RW-1:0] reg_resp_rddata;
    logic [1:0]    reg_resp_err;
    logic          uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;

    umi_reg_host #(.CW(CW), .AW(AW), .DW(DW), .RW(RW), .SRCADDR(SRC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .reg_req_valid(reg_req_valid), .reg_req_ready(reg_req_ready),
        .reg_req_write(reg_req_write), .reg_req_addr(reg_req_addr),
        .reg_req_wrdata(reg_req_wrdata),
        .reg_resp_valid(reg_resp_valid), .reg_resp_ready(reg_resp_ready),
        .reg_resp_rddata(reg_resp_rddata), .reg_resp_err(reg_resp_err),
        .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int mtag;                       // model of the next hostid the DUT will use
    logic [31:0] mem [logic [63:0]]; // register file behind the UMI device

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cmd(input bit w, input int t);
        return 32'((w ? 3 : 1) + ($clog2(RW / 8) * 32) + (1 << 22) + (1 << 23) + ((t % 32) << 27));
    endfunction

    task automatic send_resp(input int opc, input int hid, input int err,
                             input logic [63:0] dst, input logic [255:0] dat);
        uhost_resp_valid   = 1'b1;
        uhost_resp_cmd     = 32'(opc + (err << 25) + ((hid % 32) << 27));
        uhost_resp_dstaddr = dst;
        uhost_resp_srcaddr = 64'h1234;
        uhost_resp_data    = dat;
        tick();
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = '0;
        uhost_resp_data    = '0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req_ready"}, reg_req_ready, 0);
        chk({name, "_resp_valid"}, reg_resp_valid, 0);
        chk({name, "_rddata"}, reg_resp_rddata, 0);
        chk({name, "_err"}, reg_resp_err, 0);
        chk({name, "_ureq_valid"}, uhost_req_valid, 0);
        chk({name, "_ureq_cmd"}, uhost_req_cmd, 0);
        chk({name, "_ureq_dst"}, uhost_req_dstaddr, 0);
        chk({name, "_ureq_src"}, uhost_req_srcaddr, 0);
        chk({name, "_ureq_data"}, uhost_req_data, 0);
        chk({name, "_uresp_ready"}, uhost_resp_ready, 0);
    endtask

    // mode: 0 normal, 1 bad responses first, 2 no response (timeout), 3 request stall, 4 reset in WAIT
    task automatic do_txn(input bit w, input logic [63:0] addr, input logic [31:0] wd,
                          input int mode, input int derr);
        int n;
        int t;
        int opc;
        logic [255:0] dat;
        logic [31:0]  exp_rd;
        n = 0;
        while (reg_req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_idle", reg_req_ready, 1);
        reg_req_valid  = 1'b1;
        reg_req_write  = w;
        reg_req_addr   = addr;
        reg_req_wrdata = wd;
        tick();
        reg_req_valid  = 1'b0;
        t = mtag;
        chk("ureq_valid", uhost_req_valid, 1);
        chk("ureq_cmd", uhost_req_cmd, exp_cmd(w, t));
        chk("ureq_dst", uhost_req_dstaddr, addr);
        chk("ureq_src", uhost_req_srcaddr, SRC);
        chk("ureq_data", uhost_req_data, w ? 256'(wd) : 256'd0);
        chk("req_ready_busy", reg_req_ready, 0);
        if (mode == 3) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("stall_valid", uhost_req_valid, 1);
                chk("stall_cmd", uhost_req_cmd, exp_cmd(w, t));
                chk("stall_data", uhost_req_data, w ? 256'(wd) : 256'd0);
                chk("stall_req_ready", reg_req_ready, 0);
                chk("stall_no_cpl", reg_resp_valid, 0);
            end
        end
        uhost_req_ready = 1'b1;
        tick();
        uhost_req_ready = 1'b0;
        mtag = (mtag + 1) % 32;
        chk("ureq_drop", uhost_req_valid, 0);
        chk("uresp_ready", uhost_resp_ready, 1);
        if (mode == 4) begin
            #2;
            reset = 1'b1;
            #1;
            chk_all_zero("rst_mid");
            @(negedge clk);
            reset = 1'b0;
            mtag  = 0;
            tick();
            chk("rst_req_ready", reg_req_ready, 1);
            return;
        end
        if (mode == 2) begin
            for (int i = 1; i < TO; i++) begin
                tick();
                chk("to_not_yet", reg_resp_valid, 0);
            end
            tick();
            exp_rd = 32'd0;
            chk("to_valid", reg_resp_valid, 1);
            chk("to_err", reg_resp_err, 3);
        end else begin
            if (w) begin
                mem[addr] = wd;
                dat = '0;
                opc = 4;
                exp_rd = 32'd0;
            end else begin
                dat = mem.exists(addr) ? 256'(mem[addr]) : 256'd0;
                opc = 2;
                exp_rd = dat[31:0];
            end
            if (mode == 1) begin
                send_resp(opc, t + 1, 0, SRC, dat ^ 256'hFF);
                chk("bad_hid_drop", reg_resp_valid, 0);
                send_resp(opc, t, 0, SRC ^ 64'h10, dat ^ 256'hFF);
                chk("bad_dst_drop", reg_resp_valid, 0);
                send_resp(w ? 2 : 4, t, 0, SRC, dat ^ 256'hFF);
                chk("bad_opc_drop", reg_resp_valid, 0);
            end
            send_resp(opc, t, derr, SRC, dat);
            chk("cpl_valid", reg_resp_valid, 1);
            chk("cpl_err", reg_resp_err, 256'(derr));
        end
        chk("cpl_rddata", reg_resp_rddata, exp_rd);
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("cpl_hold_valid", reg_resp_valid, 1);
            chk("cpl_hold_data", reg_resp_rddata, exp_rd);
            chk("cpl_hold_req_ready", reg_req_ready, 0);
        end
        reg_resp_ready = 1'b1;
        tick();
        reg_resp_ready = 1'b0;
        chk("cpl_clear", reg_resp_valid, 0);
        chk("req_ready_back", reg_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        mtag  = 0;
        reset = 1'b1;
        reg_req_valid = 1'b0; reg_req_write = 1'b0; reg_req_addr = '0; reg_req_wrdata = '0;
        reg_resp_ready = 1'b0; uhost_req_ready = 1'b0;
        uhost_resp_valid = 1'b0; uhost_resp_cmd = '0; uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0; uhost_resp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("post_rst_req_ready", reg_req_ready, 1);
        chk("post_rst_uresp_ready", uhost_resp_ready, 1);

        do_txn(1'b1, 64'h40, 32'hDEADBEEF, 0, 0);
        do_txn(1'b0, 64'h40, 32'h0, 0, 0);
        do_txn(1'b1, 64'h44, 32'h12345678, 3, 0);
        do_txn(1'b1, 64'h48, 32'hA5A5A5A5, 2, 0);
        // Late response carrying the timed-out hostid must be dropped.
        send_resp(4, (mtag + 31) % 32, 0, SRC, '0);
        chk("late_drop", reg_resp_valid, 0);
        chk("late_req_ready", reg_req_ready, 1);
        do_txn(1'b0, 64'h44, 32'h0, 0, 0);
        do_txn(1'b0, 64'h40, 32'h0, 1, 0);
        do_txn(1'b1, 64'h4C, 32'h0BADF00D, 0, 2);
        do_txn(1'b1, 64'h50, 32'h55AA55AA, 4, 0);
        do_txn(1'b0, 64'h40, 32'h0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int md;
            md = $urandom_range(0, 2);
            if (md == 2) md = 3;
            do_txn(1'($urandom_range(0, 1)), 64'h40 + 64'(4 * $urandom_range(0, 7)),
                   $urandom, md, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
